// File: rtl/s2mm_pkg.sv
// Shared definitions for the S2MM command sequencer: state encoding,
// DataMover status bit positions and the 72-bit command packer.
package s2mm_pkg;

   typedef logic [1:0] s2mm_state_t;

   localparam s2mm_state_t ST_IDLE  = 2'd0;
   localparam s2mm_state_t ST_RUN   = 2'd1;
   localparam s2mm_state_t ST_DRAIN = 2'd2;
   localparam s2mm_state_t ST_ERROR = 2'd3;

   localparam int STS_OKAY   = 7;
   localparam int STS_SLVERR = 6;
   localparam int STS_DECERR = 5;
   localparam int STS_INTERR = 4;

   localparam int CMD_W      = 72;
   localparam int CMD_RSVD_W = 4;
   localparam int CMD_TAG_W  = 4;
   localparam int CMD_ADDR_W = 32;
   localparam int CMD_DSA_W  = 6;
   localparam int CMD_BTT_W  = 23;

   // DRR=0, EOF=0, DSA=0, TYPE=1 (INCR burst)
   function automatic logic [CMD_W-1:0] pack_s2mm_cmd(
      input logic [CMD_TAG_W-1:0]  tag,
      input logic [CMD_ADDR_W-1:0] saddr,
      input logic [CMD_BTT_W-1:0]  btt
   );
      return {{CMD_RSVD_W{1'b0}}, tag, saddr, 1'b0, 1'b0, {CMD_DSA_W{1'b0}}, 1'b1, btt};
   endfunction

   function automatic logic [31:0] ring_next(
      input logic [31:0] addr,
      input logic [31:0] step,
      input logic [31:0] base,
      input logic [31:0] ring_end
   );
      logic [31:0] sum;
      sum = addr + step;
      return (sum == ring_end) ? base : sum;
   endfunction

endpackage

// File: rtl/s2mm_cmd_sequencer.sv
// Issues DataMover S2MM write commands tiling a circular capture buffer and
// checks the returned status stream for tag order and error bits.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | nothing in flight, waiting for enable
// RUN      | issuing commands while fewer than MAX_OUT are outstanding
// DRAIN    | enable dropped; finish held command and collect status
// ERROR    | bad status seen (HALT_ON_ERR); no issue, status still counted
module s2mm_cmd_sequencer
   import s2mm_pkg::*;
#(
   parameter logic [31:0]          BASE_ADDR   = 32'h0000_0000,
   parameter logic [31:0]          BUF_BYTES   = 32'h0100_0000,
   parameter logic [CMD_BTT_W-1:0] BTT         = 23'h4_0000,
   parameter int unsigned          MAX_OUT     = 2,
   parameter bit                   HALT_ON_ERR = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   output logic [CMD_W-1:0] cmd_tdata,
   output logic             cmd_tvalid,
   input  logic             cmd_tready,
   input  logic [7:0]       sts_tdata,
   input  logic             sts_tvalid,
   output logic             sts_tready,
   output logic             busy,
   output logic             wrap,
   output logic [31:0]      done_addr,
   output logic [31:0]      seg_count,
   output logic [15:0]      err_count,
   output logic             err_flag,
   output logic [7:0]       last_sts
);

   localparam logic [31:0] BTT32    = {{(32 - CMD_BTT_W){1'b0}}, BTT};
   localparam logic [31:0] RING_END = BASE_ADDR + BUF_BYTES;
   localparam logic [3:0]  MAX_OUT4 = 4'(MAX_OUT);

   s2mm_state_t          state;
   s2mm_state_t          state_nxt;
   logic [31:0]          issue_addr;
   logic [CMD_TAG_W-1:0] issue_tag;
   logic [CMD_TAG_W-1:0] exp_tag;
   logic [3:0]           outstanding;

   logic cmd_hs;
   logic sts_hs;
   logic sts_clean;
   logic sts_ok;
   logic sts_bad;
   logic sts_retire;
   logic can_issue;
   logic issue_wraps;

   assign cmd_hs      = cmd_tvalid & cmd_tready;
   assign sts_hs      = sts_tvalid & sts_tready;
   assign sts_clean   = sts_tdata[STS_OKAY] & ~sts_tdata[STS_SLVERR]
                      & ~sts_tdata[STS_DECERR] & ~sts_tdata[STS_INTERR];
   assign sts_ok      = sts_hs & sts_clean & (sts_tdata[3:0] == exp_tag) & (outstanding != 4'd0);
   assign sts_bad     = sts_hs & ~sts_ok;
   // Spurious beats (nothing outstanding) are counted as errors but retire nothing.
   assign sts_retire  = sts_hs & (outstanding != 4'd0);
   assign can_issue   = (state == ST_RUN) & enable & ~cmd_tvalid & (outstanding < MAX_OUT4);
   assign issue_wraps = ((issue_addr + BTT32) == RING_END);
   assign busy        = (state != ST_IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (enable) state_nxt = ST_RUN;
         ST_RUN:   if (!enable) state_nxt = ST_DRAIN;
         ST_DRAIN: begin
            if (enable)
               state_nxt = ST_RUN;
            else if ((outstanding == 4'd0) && !cmd_tvalid)
               state_nxt = ST_IDLE;
         end
         default:  state_nxt = state;
      endcase
      if (HALT_ON_ERR && sts_bad)
         state_nxt = ST_ERROR;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         cmd_tvalid  <= 1'b0;
         cmd_tdata   <= '0;
         sts_tready  <= 1'b0;
         wrap        <= 1'b0;
         err_flag    <= 1'b0;
         issue_addr  <= BASE_ADDR;
         issue_tag   <= '0;
         exp_tag     <= '0;
         outstanding <= 4'd0;
         done_addr   <= BASE_ADDR;
         seg_count   <= 32'd0;
         err_count   <= 16'd0;
         last_sts    <= 8'd0;
      end else begin
         state      <= state_nxt;
         sts_tready <= 1'b1;
         wrap       <= 1'b0;

         // A raised command is held until accepted, whatever state follows.
         if (cmd_hs) begin
            cmd_tvalid <= 1'b0;
            issue_tag  <= issue_tag + 4'd1;
            issue_addr <= ring_next(issue_addr, BTT32, BASE_ADDR, RING_END);
            wrap       <= issue_wraps;
         end else if (can_issue) begin
            cmd_tvalid <= 1'b1;
            cmd_tdata  <= pack_s2mm_cmd(issue_tag, issue_addr, BTT);
         end

         if (cmd_hs && !sts_retire)
            outstanding <= outstanding + 4'd1;
         else if (!cmd_hs && sts_retire)
            outstanding <= outstanding - 4'd1;

         if (sts_hs)
            last_sts <= sts_tdata;

         if (sts_retire)
            exp_tag <= exp_tag + 4'd1;

         if (sts_ok) begin
            seg_count <= seg_count + 32'd1;
            done_addr <= ring_next(done_addr, BTT32, BASE_ADDR, RING_END);
         end

         if (sts_bad) begin
            err_flag <= 1'b1;
            if (err_count != 16'hFFFF)
               err_count <= err_count + 16'd1;
         end
      end
   end

endmodule

// File: doc/s2mm_cmd_sequencer.md
Name: s2mm_cmd_sequencer

Overview:
Upstream control stage for the AXI DataMover S2MM channel.
- Issues back-to-back 72-bit write commands that tile a circular DDR capture buffer.
- Consumes the 8-bit status stream and checks tag and error bits.
- Exposes progress counters and error flags to software and ILA.
- Replaces the ad-hoc command/status logic in the top level.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first buffer segment
BUF_BYTES, 32'h0100_0000, ring size in bytes; must be a nonzero multiple of BTT
BTT, 23'h4_0000, bytes per command; nonzero multiple of 4
MAX_OUT, 2, maximum commands in flight (1..15)
HALT_ON_ERR, 1, 1 = stop issuing and lock in ERROR on a bad status

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  level; high = run, low = drain and idle
cmd_tdata  out  72  DataMover S2MM command
cmd_tvalid  out  1  command valid
cmd_tready  in  1  command ready
sts_tdata  in  8  DataMover status: [7] OKAY, [6] SLVERR, [5] DECERR, [4] INTERR, [3:0] TAG
sts_tvalid  in  1  status valid
sts_tready  out  1  status ready
busy  out  1  state != IDLE
wrap  out  1  one-cycle pulse when the issue address wraps to BASE_ADDR
done_addr  out  32  end address (exclusive) of the last good completed segment
seg_count  out  32  good segments completed, wraps at 2^32
err_count  out  16  bad status beats, saturates at 16'hFFFF
err_flag  out  1  sticky; set on any bad status, cleared only by reset
last_sts  out  8  most recent status beat

Behaviour:
- Reset values:
  - state IDLE; cmd_tvalid 0; sts_tready 0; wrap 0; busy 0; err_flag 0.
  - issue address = BASE_ADDR; issue tag 0; expected tag 0; outstanding 0.
  - done_addr = BASE_ADDR; seg_count 0; err_count 0; last_sts 0.
- sts_tready is 1 in every cycle after reset is released.
- cmd_tdata layout, MSB to LSB:
  - 4'b0 (reserved), tag[3:0], saddr[31:0], DRR=0, EOF=0, DSA=6'b0, TYPE=1 (INCR), BTT[22:0].
  - Driven from registers.
- States: IDLE, RUN, DRAIN, ERROR.
  - IDLE -> RUN when enable=1.
  - RUN -> DRAIN when enable=0.
  - DRAIN -> IDLE when outstanding=0 and cmd_tvalid=0.
  - DRAIN -> RUN if enable returns high.
  - Any state -> ERROR on a bad status when HALT_ON_ERR=1. ERROR issues nothing, keeps accepting and counting status, and exits only on reset.
- Issue, RUN only:
  - cmd_tvalid rises on the clock edge when outstanding + (pending handshake) < MAX_OUT.
  - Once high, cmd_tvalid and cmd_tdata hold stable until cmd_tready. This holds even if enable drops; the beat completes in DRAIN.
  - Minimum one idle cycle between commands is allowed; back-to-back issue is not required.
- On a command handshake:
  - tag <= tag+1 (mod 16); outstanding += 1.
  - If addr+BTT == BASE_ADDR+BUF_BYTES: addr <= BASE_ADDR and wrap pulses 1 cycle. Otherwise addr <= addr+BTT.
  - Address arithmetic is 32-bit unsigned; no overflow check beyond the ring end.
- On a status handshake:
  - last_sts <= sts_tdata.
  - Good status = bit7=1, bits[6:4]=0, TAG = expected tag, and outstanding > 0.
  - Good: seg_count += 1; done_addr advances by BTT, wrapping identically to the issue address; expected tag += 1; outstanding -= 1.
  - Bad: err_flag <= 1; err_count += 1 (saturating).
    - If outstanding > 0: outstanding -= 1 and expected tag += 1.
    - A status beat with outstanding=0 (spurious) changes neither.
- Command and status handshakes in the same cycle: outstanding is unchanged; both effects are applied.
- Reset mid-operation returns to the reset values in the next cycle. The DataMover is reset by the same system reset sequence.

Decomposition:
- Package s2mm_pkg:
  - state enum.
  - Status bit-index constants (STS_OKAY=7, STS_SLVERR=6, STS_DECERR=5, STS_INTERR=4).
  - Command field widths.
  - Function pack_s2mm_cmd(tag, saddr, btt) returning 72 bits.
- Single module; no sub-module is warranted.

Test Plan:
All scenarios use BASE_ADDR=32'h1000_0000, BTT=23'h100, BUF_BYTES=32'h400, MAX_OUT=2.
1. Reset, enable=1, cmd_tready=1, status returned 4 cycles after each command with OKAY and the correct tag -> command saddrs are 1000_0000, 0100, 0200, 0300, then 1000_0000 with wrap pulsed once; tags are 0,1,2,3,4; seg_count=4 and done_addr=1000_0000 after the 4th status.
2. cmd_tready held 0 for 10 cycles -> cmd_tvalid stays 1 with tdata constant. At most 2 commands are outstanding while status is withheld; no third cmd_tvalid until a status arrives.
3. enable dropped while cmd_tvalid=1 and outstanding=1 -> state DRAIN; the held command completes on tready. After 2 OKAY statuses: busy=0 and IDLE; no further commands issue.
4. Status 8'h41 (SLVERR, tag 1) with HALT_ON_ERR=1 -> err_flag=1, err_count=1, last_sts=8'h41, state ERROR, no new cmd_tvalid; a subsequent reset clears everything.
5. OKAY status with tag 5 when expected is 0 -> bad: err_count=1, seg_count unchanged. A spurious status with outstanding=0 -> err_count increments and outstanding stays 0.
6. Force 70000 bad statuses -> err_count saturates at 16'hFFFF, and the same-cycle issue+status case leaves outstanding constant.
